// File: rtl/cpu_seq_pkg.sv
// Shared types and constants for the multi-cycle sequencer.
package cpu_seq_pkg;

    // State encodings are visible on o_state, so the values are fixed.
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5,
        ST_ERROR  = 3'd6,
        ST_BOOT   = 3'd7
    } seq_state_e;

    // Cycles a memory request may wait without ack before the trap.
    localparam int unsigned MEM_TIMEOUT_DEF = 255;

    // Watchdog counter width; covers the full legal timeout range.
    localparam int unsigned WDOG_W = 16;

endpackage

// File: rtl/seq_watchdog.sv
// Memory-wait watchdog: clears on a state change, counts waiting cycles,
// and flags expiry when the count reaches the limit while still waiting.
module seq_watchdog
    import cpu_seq_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              clear,
    input  logic              waiting,
    input  logic [WDOG_W-1:0] limit,
    output logic              expire
);

    logic [WDOG_W-1:0] cnt;

    // Wait counter; the sequencer leaves the waiting state at the limit,
    // so the counter never needs to saturate.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (waiting)
            cnt <= cnt + 1'b1;
    end

    // Expiry only while still waiting, so an ack in the same cycle wins.
    always_comb begin
        expire = waiting && (cnt == limit);
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXEC/MEM/WB with memory
// handshakes, stall gating, halt and watchdog traps.
// Optional feature macro: SEQ_PERF_CNT_EN adds cycle/retire counters.
module multicycle_sequencer
    import cpu_seq_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_stall,
    input  logic        i_is_load,
    input  logic        i_is_store,
    input  logic        i_rf_we,
    input  logic        i_is_halt,
    output logic        o_imem_req,
    input  logic        i_imem_ack,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    input  logic        i_dmem_ack,
    output logic        o_ir_load,
    output logic        o_rf_we,
    output logic        o_pc_update,
    output logic        o_retire,
    output logic        o_halted,
    output logic        o_error,
`ifdef SEQ_PERF_CNT_EN
    output logic [31:0] o_cycle_cnt,
    output logic [31:0] o_retire_cnt,
`endif
    output logic [2:0]  o_state
);

    localparam logic [WDOG_W-1:0] LIMIT = WDOG_W'(MEM_TIMEOUT);

    seq_state_e state_q, state_d;
    logic       wd_clear, wd_waiting, wd_expire;

    seq_watchdog u_wdog (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .clear   (wd_clear),
        .waiting (wd_waiting),
        .limit   (LIMIT),
        .expire  (wd_expire)
    );

    // Watchdog restarts on every state change, so it is zero on entry to
    // FETCH/MEM; it only advances while a request is left unacknowledged.
    always_comb begin
        wd_clear   = (state_d != state_q);
        wd_waiting = ((state_q == ST_FETCH) && !i_imem_ack) ||
                     ((state_q == ST_MEM)   && !i_dmem_ack);
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            state_q <= ST_BOOT;
        else
            state_q <= state_d;
    end

    // Next-state logic; stall is honoured only where no request is open.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_BOOT:   state_d = ST_FETCH;
            ST_FETCH:  if (i_imem_ack)      state_d = ST_DECODE;
                       else if (wd_expire)  state_d = ST_ERROR;
            ST_DECODE: if (!i_stall)        state_d = i_is_halt ? ST_HALT : ST_EXEC;
            ST_EXEC:   if (!i_stall)        state_d = (i_is_load || i_is_store) ? ST_MEM : ST_WB;
            ST_MEM:    if (i_dmem_ack)      state_d = ST_WB;
                       else if (wd_expire)  state_d = ST_ERROR;
            ST_WB:     if (!i_stall)        state_d = ST_FETCH;
            ST_HALT:   state_d = ST_HALT;
            ST_ERROR:  state_d = ST_ERROR;
            default:   state_d = ST_ERROR;
        endcase
    end

    // Output decode; load+store together is treated as a load.
    always_comb begin
        o_imem_req  = (state_q == ST_FETCH);
        o_dmem_req  = (state_q == ST_MEM);
        o_dmem_we   = (state_q == ST_MEM) && i_is_store && !i_is_load;
        o_ir_load   = (state_q == ST_FETCH) && i_imem_ack;
        o_rf_we     = (state_q == ST_WB) && i_rf_we && !i_stall;
        o_pc_update = (state_q == ST_WB) && !i_stall;
        o_retire    = (state_q == ST_WB) && !i_stall;
        o_halted    = (state_q == ST_HALT);
        o_error     = (state_q == ST_ERROR);
        o_state     = state_q;
    end

`ifdef SEQ_PERF_CNT_EN
    logic [31:0] cyc_q, ret_q;
    logic        cyc_inc;

    // Counters report totals including the current cycle/retire.
    always_comb begin
        cyc_inc      = (state_q != ST_BOOT) && (state_q != ST_HALT) &&
                       (state_q != ST_ERROR);
        o_cycle_cnt  = cyc_q + {31'd0, cyc_inc};
        o_retire_cnt = ret_q + {31'd0, o_retire};
    end

    // Performance counter state; frozen in HALT/ERROR, wraps naturally.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cyc_q <= '0;
            ret_q <= '0;
        end else begin
            cyc_q <= o_cycle_cnt;
            ret_q <= o_retire_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: vector table plus hand-written
// watchdog, halt, async-reset and (optional) perf-counter sequences.
module tb_multicycle_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic stall, is_load, is_store, rf_we, is_halt, iack, dack;
    logic imem_req, dmem_req, dmem_we, ir_load, o_rf_we, pc_upd, retire, halted, error;
    logic [2:0] st;
`ifdef SEQ_PERF_CNT_EN
    logic [31:0] cyc_cnt, ret_cnt;
`endif
    logic [8:0] outs_w;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign outs_w = {imem_req, dmem_req, dmem_we, ir_load, o_rf_we, pc_upd, retire, halted, error};

    multicycle_sequencer #(.MEM_TIMEOUT(4)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_stall     (stall),
        .i_is_load   (is_load),
        .i_is_store  (is_store),
        .i_rf_we     (rf_we),
        .i_is_halt   (is_halt),
        .o_imem_req  (imem_req),
        .i_imem_ack  (iack),
        .o_dmem_req  (dmem_req),
        .o_dmem_we   (dmem_we),
        .i_dmem_ack  (dack),
        .o_ir_load   (ir_load),
        .o_rf_we     (o_rf_we),
        .o_pc_update (pc_upd),
        .o_retire    (retire),
        .o_halted    (halted),
        .o_error     (error),
`ifdef SEQ_PERF_CNT_EN
        .o_cycle_cnt (cyc_cnt),
        .o_retire_cnt(ret_cnt),
`endif
        .o_state     (st)
    );

    // inputs: {stall, is_load, is_store, rf_we, is_halt, imem_ack, dmem_ack}
    // outs:   {imem_req, dmem_req, dmem_we, ir_load, rf_we, pc_update, retire, halted, error}
    typedef struct {
        logic [6:0] in;
        logic [2:0] st;
        logic [8:0] out;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic set_in(input logic [6:0] v);
        {stall, is_load, is_store, rf_we, is_halt, iack, dack} = v;
    endtask

    // Apply inputs for one cycle, check mid-cycle, advance past the edge.
    task automatic step(input string nm, input logic [6:0] v, input logic [2:0] est, input logic [8:0] eout);
        set_in(v);
        #1;
        chk({nm, " state"}, 32'(st), 32'(est));
        chk({nm, " outs"}, 32'(outs_w), 32'(eout));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        set_in(7'd0);
        rst_n = 1'b0;
        #3;
        chk("reset state", 32'(st), 32'd7);
        chk("reset outs", 32'(outs_w), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic addv(input logic [6:0] i, input logic [2:0] s, input logic [8:0] o);
        vec_t v;
        v.in = i; v.st = s; v.out = o;
        tbl.push_back(v);
    endtask

    initial begin
        set_in(7'd0);
        #12;

        // ALU, store with 3 wait cycles, WB stall, DECODE/MEM stall + load.
        addv(7'b0001000, 3'd7, 9'b000000000);
        addv(7'b0001010, 3'd0, 9'b100100000);
        addv(7'b0001000, 3'd1, 9'b000000000);
        addv(7'b0001000, 3'd2, 9'b000000000);
        addv(7'b0001000, 3'd4, 9'b000011100);
        addv(7'b0010010, 3'd0, 9'b100100000);
        addv(7'b0010000, 3'd1, 9'b000000000);
        addv(7'b0010000, 3'd2, 9'b000000000);
        addv(7'b0010000, 3'd3, 9'b011000000);
        addv(7'b0010000, 3'd3, 9'b011000000);
        addv(7'b0010000, 3'd3, 9'b011000000);
        addv(7'b0010001, 3'd3, 9'b011000000);
        addv(7'b0010000, 3'd4, 9'b000001100);
        addv(7'b0001010, 3'd0, 9'b100100000);
        addv(7'b0001000, 3'd1, 9'b000000000);
        addv(7'b0001000, 3'd2, 9'b000000000);
        addv(7'b1001000, 3'd4, 9'b000000000);
        addv(7'b1001000, 3'd4, 9'b000000000);
        addv(7'b0001000, 3'd4, 9'b000011100);
        addv(7'b1001011, 3'd0, 9'b100100000);
        addv(7'b1100000, 3'd1, 9'b000000000);
        addv(7'b0100000, 3'd1, 9'b000000000);
        addv(7'b0100010, 3'd2, 9'b000000000);
        addv(7'b1111001, 3'd3, 9'b010000000);
        addv(7'b0101000, 3'd4, 9'b000011100);
        addv(7'b0000000, 3'd0, 9'b100000000);

        do_reset();
        foreach (tbl[i]) step($sformatf("vec%0d", i), tbl[i].in, tbl[i].st, tbl[i].out);

        // Watchdog: FETCH counts 0..4, expires at 4 without ack.
        do_reset();
        step("wd boot", 7'b0, 3'd7, 9'b0);
        for (int k = 0; k < 5; k++) step($sformatf("wd wait%0d", k), 7'b0, 3'd0, 9'b100000000);
        step("wd error", 7'b0, 3'd6, 9'b000000001);
        step("wd sticky", 7'b0000011, 3'd6, 9'b000000001);
        step("wd sticky2", 7'b0, 3'd6, 9'b000000001);

        // Ack exactly at expiry wins.
        do_reset();
        step("wa boot", 7'b0, 3'd7, 9'b0);
        for (int k = 0; k < 4; k++) step($sformatf("wa wait%0d", k), 7'b0, 3'd0, 9'b100000000);
        step("wa ack", 7'b0000010, 3'd0, 9'b100100000);
        step("wa decode", 7'b0, 3'd1, 9'b0);

        // Halt in DECODE, later acks ignored, no retire.
        do_reset();
        step("h boot", 7'b0, 3'd7, 9'b0);
        step("h fetch", 7'b0000010, 3'd0, 9'b100100000);
        step("h decode", 7'b0000100, 3'd1, 9'b0);
        step("h halt", 7'b0001011, 3'd5, 9'b000000010);
        step("h halt2", 7'b0001011, 3'd5, 9'b000000010);

        // Async reset in MEM drops the request immediately.
        do_reset();
        step("r boot", 7'b0, 3'd7, 9'b0);
        step("r fetch", 7'b0000010, 3'd0, 9'b100100000);
        step("r decode", 7'b0010000, 3'd1, 9'b0);
        step("r exec", 7'b0010000, 3'd2, 9'b0);
        #1;
        chk("r mem req", 32'(dmem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("r async state", 32'(st), 32'd7);
        chk("r async dmem_req", 32'(dmem_req), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("r after release", 32'(st), 32'd7);

`ifdef SEQ_PERF_CNT_EN
        // Ten zero-wait ALU instructions: 40 cycles, 10 retires.
        do_reset();
        step("p boot", 7'b0, 3'd7, 9'b0);
        for (int n = 1; n <= 10; n++) begin
            step("p fetch", 7'b0001010, 3'd0, 9'b100100000);
            step("p decode", 7'b0001000, 3'd1, 9'b0);
            step("p exec", 7'b0001000, 3'd2, 9'b0);
            set_in(7'b0001000);
            #1;
            chk("p wb retire", 32'(retire), 32'd1);
            if (n == 10) begin
                chk("p retire_cnt", ret_cnt, 32'd10);
                chk("p cycle_cnt", cyc_cnt, 32'd40);
            end
            @(posedge clk);
            #1;
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard time bound so the run always ends.
    initial begin
        #20000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
